// File: rtl/bin2bcd_pkg.sv
// ----------------------------------------------------------------------------
// bin2bcd_pkg
// Shared types and constants for the sequential binary-to-BCD converter.
//   state_t         : converter FSM states (IDLE, SHIFT, DONE)
//   ADD3_THRESH     : digit value at or above which the add-3 correction applies
//   BLANK_CODE      : digit code the downstream 7-segment decoder shows as blank
//   cnt_width()     : bit width needed by the per-conversion bit counter
// ----------------------------------------------------------------------------
package bin2bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [3:0] ADD3_THRESH = 4'd5;
    localparam logic [3:0] BLANK_CODE  = 4'hF;

    // The counter is loaded with bin_w itself, so it must hold bin_w.
    function automatic int cnt_width(input int bin_w);
        return $clog2(bin_w + 1);
    endfunction

endpackage

// File: rtl/bin2bcd_seq_if.sv
// ----------------------------------------------------------------------------
// bin2bcd_seq_if
// Start/done handshake and result bus of the binary-to-BCD converter.
//   start    : request a conversion (requester -> converter)
//   bin_in   : binary value, BIN_W bits (requester -> converter)
//   busy     : conversion in progress (converter -> requester)
//   done     : one-cycle completion pulse (converter -> requester)
//   bcd_out  : packed BCD, digit 0 in [3:0] (converter -> requester)
//   overflow : value exceeded DIGITS digits (converter -> requester)
// Modports: master = requester, slave = converter.
// ----------------------------------------------------------------------------
interface bin2bcd_seq_if #(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
);

    logic                  start;
    logic [BIN_W-1:0]      bin_in;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd_out;
    logic                  overflow;

    modport master (
        output start, bin_in,
        input  busy, done, bcd_out, overflow
    );

    modport slave (
        input  start, bin_in,
        output busy, done, bcd_out, overflow
    );

endinterface

// File: rtl/bin2bcd_seq_add3_cell.sv
// ----------------------------------------------------------------------------
// bcd_add3_cell
// Combinational double-dabble correction for one BCD digit: a digit of 5 or
// more gets 3 added so that the following left shift carries into the next
// digit instead of producing a code above 9.
//   din  : 4-bit scratch digit before correction
//   dout : corrected digit
// ----------------------------------------------------------------------------
module bcd_add3_cell
    import bin2bcd_pkg::*;
(
    input  logic [3:0] din,
    output logic [3:0] dout
);

    assign dout = (din >= ADD3_THRESH) ? din + 4'd3 : din;

endmodule

// File: rtl/bin2bcd_seq.sv
// ----------------------------------------------------------------------------
// bin2bcd_seq
// Sequential binary-to-BCD converter (shift-and-add-3), one input bit per
// clock. A conversion takes BIN_W SHIFT cycles plus one DONE cycle; the result
// register only changes when done pulses, so a display fed from bcd_out never
// sees intermediate values.
//
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : bin2bcd_seq_if.slave (start, bin_in, busy, done, bcd_out, overflow)
//
// Parameters: BIN_W (4..16) input width, DIGITS (1..5) output digits.
// Optional macro BIN2BCD_BLANK_EN: replace leading zero digits with 4'hF
// (digit 0 and saturated results are never blanked).
// ----------------------------------------------------------------------------
module bin2bcd_seq
    import bin2bcd_pkg::*;
#(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    bin2bcd_seq_if.slave  bus
);

    localparam int SW    = 4 * DIGITS;
    localparam int CNT_W = cnt_width(BIN_W);

    state_t             state_q, state_d;
    logic [BIN_W-1:0]   shreg_q;
    logic [SW:0]        scr_q;     // extra MSB catches a carry out of the top digit
    logic [CNT_W-1:0]   cnt_q;
    logic               ovf_q;     // sticky: a 1 already left the scratch MSB
    logic [SW-1:0]      bcd_q;
    logic               done_q;
    logic               ovf_out_q;

    logic               load;
    logic               shift_en;
    logic               finish;
    logic [SW-1:0]      adj;
    logic [SW:0]        scr_next;
    logic               ovf_final;
    logic [SW-1:0]      result;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = SHIFT;
            SHIFT:   if (cnt_q == CNT_W'(1)) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs / datapath controls
    // ------------------------------------------------------------------
    always_comb begin
        load     = 1'b0;
        shift_en = 1'b0;
        finish   = 1'b0;
        bus.busy = 1'b0;
        case (state_q)
            IDLE:  load = bus.start;
            SHIFT: begin
                shift_en = 1'b1;
                bus.busy = 1'b1;
            end
            DONE: begin
                finish   = 1'b1;
                bus.busy = 1'b1;
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Per-digit add-3 correction, applied before every shift
    // ------------------------------------------------------------------
    for (genvar i = 0; i < DIGITS; i++) begin : g_add3
        bcd_add3_cell u_cell (
            .din  (scr_q[4*i +: 4]),
            .dout (adj[4*i +: 4])
        );
    end

    // The old scratch MSB falls off the top here; ovf_q remembers it.
    assign scr_next  = {adj, shreg_q[BIN_W-1]};
    assign ovf_final = ovf_q | scr_q[SW];

`ifdef BIN2BCD_BLANK_EN
    function automatic logic [SW-1:0] blank_leading(input logic [SW-1:0] d);
        logic [SW-1:0] r;
        logic          lead;
        r    = d;
        lead = 1'b1;
        for (int i = DIGITS - 1; i > 0; i--) begin
            if (lead && (d[4*i +: 4] == 4'h0)) r[4*i +: 4] = BLANK_CODE;
            else                               lead = 1'b0;
        end
        return r;
    endfunction

    always_comb begin
        if (ovf_final) result = {DIGITS{4'h9}};
        else           result = blank_leading(scr_q[SW-1:0]);
    end
`else
    always_comb begin
        if (ovf_final) result = {DIGITS{4'h9}};
        else           result = scr_q[SW-1:0];
    end
`endif

    // ------------------------------------------------------------------
    // Conversion datapath: shift register, scratch, counter, overflow
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg_q <= '0;
            scr_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else if (load) begin
            shreg_q <= bus.bin_in;
            scr_q   <= '0;
            cnt_q   <= CNT_W'(BIN_W);
            ovf_q   <= 1'b0;
        end else if (shift_en) begin
            shreg_q <= {shreg_q[BIN_W-2:0], 1'b0};
            scr_q   <= scr_next;
            cnt_q   <= cnt_q - CNT_W'(1);
            ovf_q   <= ovf_final;
        end
    end

    // ------------------------------------------------------------------
    // Result register: changes only when done pulses
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcd_q     <= '0;
            done_q    <= 1'b0;
            ovf_out_q <= 1'b0;
        end else begin
            done_q <= finish;
            if (finish) begin
                bcd_q     <= result;
                ovf_out_q <= ovf_final;
            end
        end
    end

    assign bus.done     = done_q;
    assign bus.bcd_out  = bcd_q;
    assign bus.overflow = ovf_out_q;

endmodule

// File: doc/bin2bcd_seq.md
Name: bin2bcd_seq

Overview:
Sequential binary-to-BCD converter using the shift-and-add-3 (double-dabble) method. It accepts a binary value through a start/done handshake and produces packed BCD digits. Each 4-bit digit drives one bcd_7_seg decoder instance directly, so this block sits immediately upstream of the display decode stage. One bit is processed per clock, which keeps area small for counter and readout displays.

Parameters:
BIN_W, 8, width of the binary input; legal range 4..16.
DIGITS, 3, number of BCD output digits; legal range 1..5.

Ports:
clk  in  1  system clock; all state updates on the rising edge.
rst_n  in  1  asynchronous, active-low reset.
start  in  1  request a conversion; sampled only in IDLE.
bin_in  in  BIN_W  binary value; captured on the accepted start cycle.
busy  out  1  high from the cycle after start is accepted until done is asserted.
done  out  1  single-cycle pulse; bcd_out is valid from this cycle onward.
bcd_out  out  4*DIGITS  packed BCD; digit 0 (units) in bits [3:0].
overflow  out  1  value did not fit in DIGITS digits; updated together with done.

Behaviour:
- Reset (async assert, sync release): state=IDLE; bcd_out=0; busy=0; done=0; overflow=0; internal shift and scratch registers cleared.
- States:
  - IDLE: if start=1, capture bin_in into a shift register, clear the BCD scratch, load the bit counter with BIN_W, go to SHIFT.
  - SHIFT: each cycle, first add 3 to every scratch digit that is >=5, then shift {scratch, shift_reg} left by 1. Decrement the counter. When the counter reaches 1 in SHIFT, go to DONE.
  - DONE: register the result to bcd_out, pulse done, return to IDLE.
- busy=1 in SHIFT and DONE.
- Latency: start accepted at edge N -> done=1 and new bcd_out visible after edge N+BIN_W+1. Throughput is one conversion per BIN_W+2 cycles.
- start while busy is ignored. start in the DONE cycle is ignored; it is accepted on the next IDLE cycle. bin_in is don't-care except on the accepted start cycle.
- bcd_out holds the previous result during a conversion and changes only in the DONE cycle. This gives glitch-free display.
- Scratch width: 4*DIGITS+1 bits. The extra MSB catches a carry out of the top digit.
- overflow: set if any 1 is shifted beyond bit 4*DIGITS-1 during the conversion (sticky within the conversion). On overflow, bcd_out saturates to all digits = 4'h9 and overflow=1. Otherwise overflow=0.
- Every non-saturated digit is in the range 0..9. 4'hA..4'hE never appear on bcd_out.
- Reset mid-conversion aborts immediately: no done pulse, and bcd_out returns to 0.
- bin_in=0 yields all-zero digits after the full latency. There is no early termination.

Optional Feature:
Macro: BIN2BCD_BLANK_EN.
- Defined: leading-zero blanking. In the DONE cycle, every digit more significant than the highest nonzero digit is replaced by 4'hF, which the downstream decoder renders as blank. Digit 0 is never blanked, so value 0 shows "0". Saturated overflow output is not blanked.
- Undefined: leading zeros are output as 4'h0. No extra logic is generated.

Decomposition:
- Package bin2bcd_pkg:
  - state enum {IDLE, SHIFT, DONE}.
  - localparam ADD3_THRESH=4'd5.
  - localparam BLANK_CODE=4'hF.
  - function for counter width: $clog2(BIN_W+1).
- Sub-module bcd_add3_cell: 4-bit combinational cell (in>=5 ? in+3 : in), instantiated DIGITS times via generate.
- FSM, counter and output register stay in bin2bcd_seq.

Test Plan:
- bin_in=0, start pulse (defaults) -> done after exactly 9 cycles. bcd_out=12'h000 (blank build: 12'hFF0), overflow=0, busy high for 9 cycles.
- bin_in=255 -> bcd_out=12'h255, overflow=0. bin_in=99 -> 12'h099 (blank build: 12'hF99). bin_in=7 -> 12'h007 (blank build: 12'hFF7).
- start held high continuously with bin_in changing -> conversions are accepted only in IDLE, back to back every 10 cycles. Each result matches bin_in at its accepting edge.
- start with bin_in=200, then start again with bin_in=50 on the 3rd busy cycle -> second request ignored. bcd_out=12'h200, a single done pulse.
- rst_n low at the 4th SHIFT cycle of a conversion -> no done. bcd_out=0, busy=0 immediately. A new start afterwards converts 128 to 12'h128 correctly.
- DIGITS=2, bin_in=255 -> bcd_out=8'h99, overflow=1. Then bin_in=42 -> 8'h42, overflow=0.
